// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: plays packed (A, B, opcode) commands into the calculator strobe port and returns result/zero.
// Define CALC_SEQ_CMD_FIFO_EN to put a FIFO_DEPTH-entry in-order command queue in front of the sequencer.
module calc_cmd_sequencer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [7:0] user_input,
    output logic       load_a,
    output logic       load_b,
    output logic [2:0] user_opcode,
    output logic       load_opcode,
    output logic       execute,
    input  logic [7:0] calc_result,
    input  logic       calc_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic [7:0] done_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESP} state_t;

    state_t      state, state_nx;
    logic [7:0]  a_q, b_q;
    logic [2:0]  op_q;
    logic [18:0] src;
    logic        avail;
    logic        take;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

`ifdef CALC_SEQ_CMD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          full, push;

    assign full      = cnt == (AW + 1)'(FIFO_DEPTH);
    assign push      = cmd_valid && !full;
    assign cmd_ready = !rst && !full;
    assign avail     = cnt != '0;
    assign src       = mem[rp];

    always_ff @(posedge clk)
        if (push) mem[wp] <= {cmd_op, cmd_b, cmd_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (take) rp <= rp + 1'b1;
            cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(take);
        end
    end
`else
    assign cmd_ready = !rst && state == IDLE;
    assign avail     = cmd_valid;
    assign src       = {cmd_op, cmd_b, cmd_a};
`endif

    assign take        = state == IDLE && avail;
    assign user_opcode = op_q;

    always_comb begin
        state_nx    = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_opcode = 1'b0;
        execute     = 1'b0;
        rsp_valid   = 1'b0;
        user_input  = 8'h00;
        case (state)
            IDLE:    state_nx = take ? LOAD_A : IDLE;
            LOAD_A: begin
                state_nx    = LOAD_B;
                load_a      = 1'b1;
                load_opcode = 1'b1;
                user_input  = a_q;
            end
            LOAD_B: begin
                state_nx   = EXEC;
                load_b     = 1'b1;
                user_input = b_q;
            end
            EXEC: begin
                state_nx = CAPTURE;
                execute  = 1'b1;
            end
            CAPTURE: state_nx = RESP;
            RESP: begin
                state_nx  = rsp_ready ? IDLE : RESP;
                rsp_valid = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            done_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (take) {op_q, b_q, a_q} <= src;
            if (state == CAPTURE) begin
                rsp_result <= calc_result;
                rsp_zero   <= calc_zero;
            end
            if (state == RESP && rsp_ready) done_cnt <= done_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed bench for calc_cmd_sequencer driving an XOR stub calculator.
module tb_calc_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [7:0] user_input;
    logic       load_a, load_b, load_opcode, execute;
    logic [2:0] user_opcode;
    logic [7:0] calc_result;
    logic       calc_zero;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic [7:0] done_cnt;

    logic [7:0] sa, sb;
    int passed = 0;
    int total  = 0;
    int exp_cnt = 0;

    calc_cmd_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .user_input(user_input), .load_a(load_a), .load_b(load_b),
        .user_opcode(user_opcode), .load_opcode(load_opcode), .execute(execute),
        .calc_result(calc_result), .calc_zero(calc_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Stub calculator: result = A ^ B, registered on execute
    always_ff @(posedge clk) begin
        if (load_a) sa <= user_input;
        if (load_b) sb <= user_input;
        if (execute) begin
            calc_result <= sa ^ sb;
            calc_zero   <= (sa ^ sb) == 8'h00;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin step; n++; end
        chk("send_ready", cmd_ready, 1);
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [7:0] res, output logic z);
        int n = 0;
        while (!rsp_valid && n < 20) begin step; n++; end
        chk("rsp_wait", rsp_valid, 1);
        res = rsp_result;
        z   = rsp_zero;
    endtask

    task automatic xfer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output logic [7:0] res, output logic z);
        send(a, b, op);
        wait_rsp(res, z);
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    initial begin
        logic [7:0] res;
        logic       z;
        logic       seen;
        int         n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        #12;
        chk("rst_strobes", {load_a, load_opcode, load_b, execute}, 4'b0000);
        chk("rst_user_input", user_input, 8'h00);
        chk("rst_user_opcode", user_opcode, 3'd0);
        chk("rst_rsp", {rsp_valid, rsp_zero, rsp_result}, 10'h000);
        chk("rst_done_cnt", done_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single command, cycle by cycle
        cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 3'b001; cmd_valid = 1'b1;
        step;
`ifdef CALC_SEQ_CMD_FIFO_EN
        cmd_valid = 1'b0;
        step;
`endif
        cmd_valid = 1'b0;
        chk("e1_strobes", {load_a, load_opcode, load_b, execute}, 4'b1100);
        chk("e1_user_input", user_input, 8'h12);
        chk("e1_user_opcode", user_opcode, 3'b001);
        step;
        chk("e2_strobes", {load_a, load_opcode, load_b, execute}, 4'b0010);
        chk("e2_user_input", user_input, 8'h34);
        step;
        chk("e3_strobes", {load_a, load_opcode, load_b, execute}, 4'b0001);
        chk("e3_user_input", user_input, 8'h00);
        step;
        chk("cap_strobes", {load_a, load_opcode, load_b, execute}, 4'b0000);
        chk("cap_rsp_valid", rsp_valid, 0);
        step;
        chk("e4_rsp_valid", rsp_valid, 1);
        chk("e4_rsp_result", rsp_result, 8'h26);
        chk("e4_rsp_zero", rsp_zero, 0);
`ifndef CALC_SEQ_CMD_FIFO_EN
        chk("e4_cmd_ready", cmd_ready, 0);
`endif
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        exp_cnt = 1;
        chk("e5_rsp_valid", rsp_valid, 0);
        chk("e5_done_cnt", done_cnt, 8'd1);
        chk("e5_cmd_ready", cmd_ready, 1);
        chk("e5_user_opcode_held", user_opcode, 3'b001);

        // Zero result and another pattern
        xfer(8'h5A, 8'h5A, 3'b001, res, z);
        chk("zero_result", res, 8'h00);
        chk("zero_flag", z, 1);
        xfer(8'hFF, 8'h0F, 3'b101, res, z);
        chk("ff0f_result", res, 8'hF0);
        chk("ff0f_zero", z, 0);
        chk("ff0f_opcode", user_opcode, 3'b101);
        chk("done_cnt_3", done_cnt, 8'(exp_cnt));

        // Backpressure for 5 cycles
        send(8'hA5, 8'h0F, 3'b010);
        wait_rsp(res, z);
        chk("bp_first", res, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 8'hAA);
            chk("bp_strobes", {load_a, load_opcode, load_b, execute}, 4'b0000);
`ifndef CALC_SEQ_CMD_FIFO_EN
            chk("bp_cmd_ready", cmd_ready, 0);
`endif
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("bp_release", rsp_valid, 0);
        chk("bp_done_cnt", done_cnt, 8'(exp_cnt));

        // Reset asserted mid-cycle during EXEC
        send(8'h33, 8'h44, 3'b011);
        n = 0;
        while (!execute && n < 20) begin step; n++; end
        chk("exec_reached", execute, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_strobes", {load_a, load_opcode, load_b, execute}, 4'b0000);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_user_opcode", user_opcode, 3'd0);
        chk("mid_rst_done_cnt", done_cnt, 8'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin step; seen |= rsp_valid; end
        chk("post_rst_no_rsp", seen, 0);
        xfer(8'h33, 8'h44, 3'b011, res, z);
        chk("post_rst_result", res, 8'h77);
        chk("post_rst_done_cnt", done_cnt, 8'd1);

`ifdef CALC_SEQ_CMD_FIFO_EN
        begin
            int k = 0;
            int got = 0;
            logic saw_full = 1'b0;
            rsp_ready = 1'b1;
            for (int c = 0; c < 80 && got < 4; c++) begin
                if (rsp_valid) begin
                    chk("fifo_order", rsp_result, 8'(got + 1) ^ 8'(8'h10 * (got + 1)));
                    got++;
                end
                cmd_valid = k < 4;
                cmd_a = 8'(k + 1); cmd_b = 8'(8'h10 * (k + 1)); cmd_op = 3'b001;
                if (k < 4 && !cmd_ready) saw_full = 1'b1;
                if (cmd_valid && cmd_ready) k++;
                step;
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            exp_cnt += 4;
            chk("fifo_got4", got, 4);
            chk("fifo_full_seen", saw_full, 1);
            chk("fifo_done_cnt", done_cnt, 8'(exp_cnt));
        end
`endif

        // Run the counter up to 255 then wrap
        while (exp_cnt != 255) xfer(8'(exp_cnt), 8'h01, 3'b001, res, z);
        chk("cnt_255", done_cnt, 8'd255);
        xfer(8'hC3, 8'h3C, 3'b001, res, z);
        chk("wrap_result", res, 8'hFF);
        chk("cnt_wrap", done_cnt, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/calc_cmd_sequencer.md
# calc_cmd_sequencer

Command-side driver for the 8-bit calculator block. Accepts a packed operation (A, B, opcode) on a valid/ready command port and plays it into the calculator's strobe interface as load_a, load_b, load_opcode and execute pulses. It then captures the calculator's result and zero flag and returns them on a valid/ready response port. It sits between a host (UART/register front-end or testbench) and the calculator, so the host never hand-sequences strobes.

## Interface
- FIFO_DEPTH, 2, command queue depth; used only with CALC_SEQ_CMD_FIFO_EN; must be a power of two, ≥2.

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on edge where cmd_valid&&cmd_ready
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  opcode
- user_input  out  8  operand bus to calculator
- load_a  out  1  one-cycle strobe: calculator latches user_input as A
- load_b  out  1  one-cycle strobe: calculator latches user_input as B
- user_opcode  out  3  opcode bus to calculator
- load_opcode  out  1  one-cycle strobe: calculator latches user_opcode
- execute  out  1  one-cycle strobe: calculator registers result/zero_flag
- calc_result  in  8  calculator result output
- calc_zero  in  1  calculator zero_flag output
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed on edge where rsp_valid&&rsp_ready
- rsp_result  out  8  captured result
- rsp_zero  out  1  captured zero flag
- done_cnt  out  8  completed-response counter, wraps 255→0

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESP.
- IDLE: when a command is available, latch A/B/op and go to LOAD_A.
- LOAD_A: user_input=A, load_a=1, load_opcode=1. LOAD_B: user_input=B, load_b=1. EXEC: execute=1.
- CAPTURE: no strobes; sample calc_result/calc_zero into rsp regs; go to RESP.
- RESP: rsp_valid=1. On handshake: done_cnt++ (mod 256), go to IDLE.
- user_input is 0 outside LOAD_A/LOAD_B. user_opcode holds the latched op from LOAD_A until the next command.
- Strobes decode from the state register only. No combinational path from any input to any calculator-side output.
- At most one strobe group is active per cycle. Strobes never assert in IDLE, CAPTURE or RESP.
- rsp_result/rsp_zero stay stable while rsp_valid=1 and rsp_ready=0. Backpressure is unlimited.
- Reset (any state, mid-operation): state=IDLE and all strobes drop immediately. user_input=0, user_opcode=0, rsp_valid=0, rsp_result=0, rsp_zero=0, done_cnt=0, queue emptied. cmd_ready=1 once reset deasserts.

## Timing
- Command accepted at edge E0. Strobes are sampled by the calculator at E1 (load_a/load_opcode), E2 (load_b) and E3 (execute).
- Capture occurs at E4. rsp_valid is high after E4 (4-cycle latency).
- With rsp_ready held high, the handshake occurs at E5 and the state returns to IDLE after E5.
- Non-FIFO mode: next acceptance no earlier than E6, so peak throughput is 1 command per 6 cycles.
- Simultaneous cmd_valid and RESP handshake: the command is not accepted that cycle (cmd_ready=0 outside IDLE).

## Configuration
- CALC_SEQ_CMD_FIFO_EN defined: a FIFO_DEPTH-entry in-order command queue sits in front of the sequencer.
  - cmd_ready = !full, independent of sequencer state.
  - IDLE pops the head when non-empty; the pop edge equals E0 above.
  - Simultaneous push and pop are both honoured. Push while full is ignored.
- Undefined: no queue. cmd_ready = (state==IDLE), and the command is latched directly.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 asynchronously. After release cmd_ready=1, done_cnt=0.
- Single command (A=0x12, B=0x34, op=3'b001) against a stub calculator returning A^B:
  - load_a/load_opcode at E1 with user_input=0x12, load_b at E2 with 0x34, execute at E3.
  - rsp_valid after E4 with rsp_result=0x26, rsp_zero=0. done_cnt=1 after handshake.
- Zero result: A=B=0x5A with the XOR stub → rsp_result=0x00, rsp_zero=1.
- Backpressure: rsp_ready=0 for 5 cycles → response held stable, cmd_ready=0 (non-FIFO), no strobes. Handshake on the first cycle rsp_ready=1.
- Reset during EXEC → execute drops in the same cycle, rsp_valid never asserts. The next command completes normally with correct result.
- CALC_SEQ_CMD_FIFO_EN: stream 4 back-to-back commands with cmd_valid held → cmd_ready deasserts while 2 are queued, 4 in-order responses, done_cnt=4.
  - Preload done_cnt to 255 via 255 prior commands → wraps to 0.
